// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and the
// default serial bit period in clock cycles.
package uart_pkg;

   localparam int DEFAULT_CLOCKS_PER_BIT = 55;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA_RX = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bundle: the received byte plus its status strobes.
// The receiver drives it (master), the consumer reads it (slave).
interface uart_rx_if;

   logic [7:0] out_data_byte;
   logic       rx_done;
   logic       rx_frame_err;
   logic       rx_busy;

   modport master (
      output out_data_byte,
      output rx_done,
      output rx_frame_err,
      output rx_busy
   );

   modport slave (
      input out_data_byte,
      input rx_done,
      input rx_frame_err,
      input rx_busy
   );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset
// to RESET_VAL so an idle-high line does not look like a start edge.
module sync_2ff #(
   parameter bit RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is synchronized, the start bit is confirmed
// at its mid-point, then each data bit and the stop bit are sampled at
// their centres. A good stop bit publishes the byte with rx_done; a low
// stop bit pulses rx_frame_err and leaves the published byte alone.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
   parameter int HALF_BIT       = (CLOCKS_PER_BIT - 1) / 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     rx_in,
   uart_rx_if.master rx_bus
);

   localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

   logic             rx_s;

   uart_state_e      state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [2:0]       bit_index, bit_index_next;
   logic [7:0]       shift_reg, shift_reg_next;
   logic [7:0]       data_q, data_next;
   logic             done_q, done_next;
   logic             err_q, err_next;
   // Set by a framing error; while set, a low line is treated as a break
   // and never confirmed as a start bit. Cleared once the line idles high.
   logic             brk_q, brk_next;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_in),
      .q     (rx_s)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_index <= '0;
         shift_reg <= '0;
         data_q    <= 8'h00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         brk_q     <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         bit_index <= bit_index_next;
         shift_reg <= shift_reg_next;
         data_q    <= data_next;
         done_q    <= done_next;
         err_q     <= err_next;
         brk_q     <= brk_next;
      end
   end

   // Next-state and datapath update for the receive sequence.
   // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      bit_index_next = bit_index;
      shift_reg_next = shift_reg;
      data_next      = data_q;
      done_next      = 1'b0;
      err_next       = 1'b0;
      brk_next       = brk_q;

      case (state)
         IDLE: begin
            cnt_next       = '0;
            bit_index_next = '0;
            if (rx_s) begin
               brk_next = 1'b0;
            end else begin
               state_next = START;
            end
         end

         START: begin
            if (cnt == CNT_HALF) begin
               cnt_next = '0;
               if (!rx_s && !brk_q) begin
                  state_next = DATA_RX;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         DATA_RX: begin
            if (cnt == CNT_LAST) begin
               cnt_next                  = '0;
               shift_reg_next[bit_index] = rx_s;
               if (bit_index == 3'd7) begin
                  bit_index_next = '0;
                  state_next     = STOP;
               end else begin
                  bit_index_next = bit_index + 3'd1;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_next   = '0;
               state_next = CLEANUP;
               if (rx_s) begin
                  data_next = shift_reg;
                  done_next = 1'b1;
               end else begin
                  err_next = 1'b1;
                  brk_next = 1'b1;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         CLEANUP: begin
            cnt_next       = '0;
            bit_index_next = '0;
            state_next     = IDLE;
         end

         default: begin
            cnt_next       = '0;
            bit_index_next = '0;
            state_next     = IDLE;
         end
      endcase
   end

   assign rx_bus.out_data_byte = data_q;
   assign rx_bus.rx_done       = done_q;
   assign rx_bus.rx_frame_err  = err_q;
   assign rx_bus.rx_busy       = (state != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLOCKS_PER_BIT, default 55, meaning clk cycles per serial bit.
REQ-002 The block SHALL have parameter HALF_BIT, default (CLOCKS_PER_BIT-1)/2 = 27, meaning the start-bit mid-point count.
REQ-003 The block SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port rx_in, input, 1, meaning the asynchronous serial line from the computer, idle high.
REQ-006 The block SHALL have port out_data_byte, output, 8, meaning the last correctly framed byte, held until the next good frame.
REQ-007 The block SHALL have port rx_done, output, 1, meaning a one-cycle pulse that out_data_byte was just updated.
REQ-008 The block SHALL have port rx_frame_err, output, 1, meaning a one-cycle pulse that the stop bit was sampled low.
REQ-009 The block SHALL have port rx_busy, output, 1, meaning high in every state except IDLE.

Function
REQ-010 rx_in SHALL pass through a 2-flop synchronizer reset to 1; all logic SHALL use only the synchronized value rx_s.
REQ-011 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, and one stop bit (1).
REQ-012 The FSM SHALL have states IDLE, START, DATA_RX, STOP and CLEANUP; any unused encoding SHALL go to IDLE.
REQ-013 In IDLE, the counter and bit index SHALL be 0; rx_s==0 SHALL move the FSM to START.
REQ-014 In START, the counter SHALL increment until it equals HALF_BIT; if rx_s is still 0 at that point, the counter SHALL clear and the FSM SHALL go to DATA_RX; otherwise it SHALL return to IDLE (glitch rejection, no output pulse).
REQ-015 In DATA_RX, each bit SHALL be sampled when the counter reaches CLOCKS_PER_BIT-1 (bit centre), then the counter SHALL clear.
REQ-016 Each sampled bit SHALL be written into shift_reg[bit_index]; after bit 7 the index SHALL wrap to 0 and the FSM SHALL go to STOP.
REQ-017 In STOP, the stop bit SHALL be sampled after CLOCKS_PER_BIT-1 counts. If it is 1: out_data_byte<=shift_reg and rx_done=1 for one cycle. If it is 0: rx_frame_err=1 for one cycle and out_data_byte is unchanged. The FSM SHALL then go to CLEANUP.
REQ-018 CLEANUP SHALL last exactly 1 cycle and then go to IDLE; a start edge already present is accepted on the next IDLE cycle (back-to-back frames).
REQ-019 rx_done and rx_frame_err SHALL never be high together and SHALL each be high for exactly one cycle per frame.
REQ-020 Latency from the first rx_in low edge to the rx_done pulse SHALL be 2 + HALF_BIT + 9*CLOCKS_PER_BIT + 2 cycles, ±1 cycle.
REQ-021 The counter SHALL be at least clog2(CLOCKS_PER_BIT) bits wide and SHALL never exceed CLOCKS_PER_BIT-1.
REQ-022 A break condition (line held low) SHALL produce exactly one rx_frame_err, then wait in IDLE and START for rx_s to return high before another frame can complete.

Reset
REQ-023 rst_n low SHALL asynchronously force: state=IDLE, counter=0, bit_index=0, shift_reg=0, out_data_byte=8'h00, rx_done=0, rx_frame_err=0, rx_busy=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, the next falling edge starts a new frame.
REQ-025 Reset release SHALL be synchronized externally; the block SHALL need no extra deassertion logic.

Structure
REQ-026 State encodings (3-bit) and the default CLOCKS_PER_BIT SHALL live in the shared package uart_pkg, used by both TX and RX.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff (parameter RESET_VAL=1).
REQ-028 The block SHALL contain no other sub-modules and no multicycle paths.

Verification
REQ-029 Send byte 8'hA5 at 55 clk/bit -> out_data_byte=8'hA5, one rx_done pulse, rx_frame_err=0.
REQ-030 Send a 10-cycle low glitch on idle rx_in -> FSM returns to IDLE, no rx_done or rx_frame_err, out_data_byte unchanged.
REQ-031 Send 8'h3C with the stop bit forced to 0 -> one rx_frame_err pulse, out_data_byte keeps its previous value.
REQ-032 Send 8'h00 then 8'hFF back-to-back (one stop bit, no gap) -> two rx_done pulses with outputs 8'h00 then 8'hFF.
REQ-033 Assert rst_n low during data bit 4 of 8'h5A, then send 8'hC3 -> no pulse for the first frame, out_data_byte=8'hC3 after the second.
REQ-034 Hold rx_in low for 20 bit times, then release and send 8'h81 -> exactly one rx_frame_err, then rx_done with 8'h81.
